sd_cmd_send: RTL and testbench
==============================

// Module: sd_cmd_send
// PURPOSE
// - Host-side SD command transmitter: serializes a 48-bit SD command frame onto the CMD line.
// - Frame: start(0), transmission(1), index[5:0], argument[31:0], CRC7, end(1).
// - CRC7 is computed serially as the bits go out.
// - Sits in the host controller next to the response receiver; the controller FSM pulses
//   send_en, waits for sd_send_finished, then enables response reception.
// PARAMETERS
// - CLK_DIV  4  ex_clk cycles per CMD bit; legal range >= 2.
// PORTS
// - ex_clk            in   1   system clock; all logic on rising edge
// - reset             in   1   asynchronous, active-high
// - send_en           in   1   request; sampled only in IDLE
// - cmd_index         in   6   command index; captured on acceptance
// - argument          in   32  command argument; captured on acceptance
// - sd_cmd_out        out  1   CMD line data; 1 when not driving a frame bit
// - sd_cmd_oe         out  1   CMD line output enable; 1 while the frame is driven
// - busy              out  1   high from the cycle after acceptance until IDLE
// - sd_send_started   out  1   1-cycle pulse in the first cycle the start bit is driven
// - sd_send_finished  out  1   1-cycle pulse after the end bit completes
// BEHAVIOUR
// - Clock/reset: single clock ex_clk; reset asynchronous, active-high.
// - Reset values: state IDLE, sd_cmd_out=1, sd_cmd_oe=0, busy=0, both pulses 0,
//   crc=0, counters=0.
// - Reset mid-frame: abort immediately, release the line (oe=0), and do not issue finished.
// - Registers: 40-bit shift reg sh = {2'b01, cmd_index, argument}, MSB first.
//   crc[6:0]; bit_cnt[5:0]; div_cnt with width clog2(CLK_DIV).
// - Bit tick: tick = (div_cnt == CLK_DIV-1). div_cnt increments every cycle while
//   not IDLE and wraps to 0 on tick. Each bit is held exactly CLK_DIV cycles.
// - IDLE: oe=0, out=1.
//   - If send_en=1: latch sh, crc=0, bit_cnt=0, div_cnt=0, go to SEND.
//   - The first bit is driven on the next cycle; sd_send_started pulses in that cycle.
// - SEND: out=sh[39], oe=1. On tick:
//   - crc <= {crc[5:0],0} ^ ({7{crc[6]^sh[39]}} & 7'h09)   (poly x^7+x^3+1)
//   - sh <= sh<<1; bit_cnt++
//   - After the 40th tick, clear bit_cnt and go to CRC.
// - CRC: out=crc[6], oe=1. On tick: crc <= crc<<1; bit_cnt++.
//   After the 7th tick, go to STOP.
// - STOP: out=1, oe=1. On tick: go to IDLE with oe=0 in that same transition.
//   sd_send_finished pulses in the first IDLE cycle.
// - Latency: acceptance edge to finished pulse = 48*CLK_DIV + 1 cycles. oe is high for
//   exactly 48*CLK_DIV cycles.
// - send_en while busy is ignored and never queued.
// - send_en held high continuously: a new frame is accepted in the cycle finished pulses,
//   which is the first IDLE cycle. The line is released for one cycle between frames.
// - cmd_index and argument changes after acceptance do not affect the frame in flight.
// - Inputs are don't-care outside the acceptance cycle.
// - No X on any output after reset.
// TESTING
// - CMD0, arg 0, CLK_DIV=4: serial capture = 48'h40_0000_0000_95 (CRC7 7'h4A);
//   finished pulses 193 cycles after acceptance.
// - CMD8, arg 32'h0000_01AA: serial capture = 48'h48_0000_01AA_87 (CRC7 7'h43).
// - CLK_DIV=2, CMD0: each bit is held 2 cycles; oe high for exactly 96 cycles;
//   started and finished are each one cycle wide.
// - send_en pulsed at bit 20 of a frame with a different index: the current frame is
//   unchanged and no second frame follows.
// - reset asserted at bit 30: oe=0, out=1, and busy=0 immediately; no finished pulse.
//   The next send_en produces a correct CMD0 frame.
// - send_en held high: back-to-back CMD8 frames, each correct, with exactly one
//   oe-low cycle between them.

Source files
------------

// File: rtl/sd_cmd_send.sv
// Host-side SD command transmitter: serializes a 48-bit command frame
// (start, transmission, index, argument, CRC7, end) onto the CMD line.
module sd_cmd_send #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        ex_clk,
    input  logic        reset,
    input  logic        send_en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        sd_send_started,
    output logic        sd_send_finished
);

    localparam int unsigned DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CRC,
        STOP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [39:0]    sh;
    logic [6:0]     crc;
    logic [5:0]     bit_cnt;
    logic [DW-1:0]  div_cnt;
    logic           finished_q;
    logic           tick;

    assign tick = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge ex_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Line outputs decode straight from state so an asynchronous reset
    // releases the CMD line in the same instant it is asserted.
    always_comb begin
        state_nx        = state;
        sd_cmd_out      = 1'b1;
        sd_cmd_oe       = 1'b0;
        sd_send_started = 1'b0;
        case (state)
            IDLE: begin
                if (send_en) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                sd_cmd_out      = sh[39];
                sd_cmd_oe       = 1'b1;
                sd_send_started = (bit_cnt == 6'd0) && (div_cnt == '0);
                if (tick && (bit_cnt == 6'd39)) begin
                    state_nx = CRC;
                end
            end
            CRC: begin
                sd_cmd_out = crc[6];
                sd_cmd_oe  = 1'b1;
                if (tick && (bit_cnt == 6'd6)) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                sd_cmd_oe = 1'b1;
                if (tick) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy             = (state != IDLE);
    assign sd_send_finished = finished_q;

    always_ff @(posedge ex_clk or posedge reset) begin
        if (reset) begin
            sh         <= '0;
            crc        <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            finished_q <= 1'b0;
        end else begin
            finished_q <= (state == STOP) && tick;
            if (state == IDLE) begin
                if (send_en) begin
                    sh      <= {2'b01, cmd_index, argument};
                    crc     <= '0;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                if (tick) begin
                    case (state)
                        SEND: begin
                            crc     <= {crc[5:0], 1'b0} ^ ({7{crc[6] ^ sh[39]}} & 7'h09);
                            sh      <= sh << 1;
                            bit_cnt <= (bit_cnt == 6'd39) ? 6'd0 : bit_cnt + 6'd1;
                        end
                        CRC: begin
                            crc     <= crc << 1;
                            bit_cnt <= (bit_cnt == 6'd6) ? 6'd0 : bit_cnt + 6'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_send.sv
// Self-checking bench for sd_cmd_send: directed vectors, random frames against a
// polynomial-division CRC7 model, and multi-cycle corner sequences.
module tb_sd_cmd_send;

    logic        ex_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        en4    = 1'b0;
    logic        en2    = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] argument  = '0;

    logic out4, oe4, busy4, st4, fin4;
    logic out2, oe2, busy2, st2, fin2;

    sd_cmd_send #(.CLK_DIV(4)) dut4 (
        .ex_clk(ex_clk), .reset(reset), .send_en(en4),
        .cmd_index(cmd_index), .argument(argument),
        .sd_cmd_out(out4), .sd_cmd_oe(oe4), .busy(busy4),
        .sd_send_started(st4), .sd_send_finished(fin4)
    );

    sd_cmd_send #(.CLK_DIV(2)) dut2 (
        .ex_clk(ex_clk), .reset(reset), .send_en(en2),
        .cmd_index(cmd_index), .argument(argument),
        .sd_cmd_out(out2), .sd_cmd_oe(oe2), .busy(busy2),
        .sd_send_started(st2), .sd_send_finished(fin2)
    );

    always #5 ex_clk = ~ex_clk;

    int   sel = 0;
    logic s_out, s_oe, s_busy, s_st, s_fin;
    always_comb begin
        if (sel == 0) {s_out, s_oe, s_busy, s_st, s_fin} = {out4, oe4, busy4, st4, fin4};
        else          {s_out, s_oe, s_busy, s_st, s_fin} = {out2, oe2, busy2, st2, fin2};
    end

    int checks   = 0;
    int failures = 0;
    logic out_q[$], oe_q[$], busy_q[$], st_q[$], fin_q[$];

    typedef struct {
        int          s;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] exp;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of body*x^7 divided by x^7+x^3+1
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        logic [46:0] r;
        body = {2'b01, idx, arg};
        r = {body, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return {body, r[6:0], 1'b1};
    endfunction

    task automatic clr();
        out_q.delete(); oe_q.delete(); busy_q.delete(); st_q.delete(); fin_q.delete();
    endtask

    task automatic rec();
        out_q.push_back(s_out); oe_q.push_back(s_oe); busy_q.push_back(s_busy);
        st_q.push_back(s_st); fin_q.push_back(s_fin);
    endtask

    task automatic set_en(input logic v);
        if (sel == 0) en4 = v;
        else          en2 = v;
    endtask

    task automatic check_frame(input int start, input int d, input logic [47:0] exp, input string name);
        logic [47:0] cap;
        int hold_err = 0;
        int oe_err   = 0;
        int st_cnt   = 0;
        int fin_cnt  = 0;
        for (int k = 0; k < 48; k++) begin
            cap[47-k] = out_q[start + k*d];
            for (int j = 0; j < d; j++) begin
                if (out_q[start + k*d + j] !== exp[47-k]) hold_err++;
                if (oe_q[start + k*d + j] !== 1'b1 || busy_q[start + k*d + j] !== 1'b1) oe_err++;
            end
        end
        for (int c = start; c <= start + 48*d; c++) begin
            if (st_q[c] === 1'b1) st_cnt++;
            if (fin_q[c] === 1'b1) fin_cnt++;
        end
        chk({name, " frame"}, 64'(cap), 64'(exp));
        chk({name, " bit_hold"}, 64'(hold_err), 64'd0);
        chk({name, " oe_busy_window"}, 64'(oe_err), 64'd0);
        chk({name, " edges_low"}, {oe_q[start-1], busy_q[start-1], oe_q[start+48*d], busy_q[start+48*d]}, 64'd0);
        chk({name, " started_first"}, 64'(st_q[start]), 64'd1);
        chk({name, " started_count"}, 64'(st_cnt), 64'd1);
        chk({name, " finished_latency"}, 64'(fin_q[start + 48*d]), 64'd1);
        chk({name, " finished_count"}, 64'(fin_cnt), 64'd1);
    endtask

    task automatic send_frame(input int s, input logic [5:0] idx, input logic [31:0] arg,
                              input logic [47:0] exp, input int pulse_c, input string name);
        int d;
        d   = (s == 0) ? 4 : 2;
        sel = s;
        @(negedge ex_clk);
        cmd_index = idx;
        argument  = arg;
        set_en(1'b1);
        clr();
        rec();
        for (int c = 1; c <= 48*d + 3; c++) begin
            @(negedge ex_clk);
            rec();
            if (c == 1) begin
                set_en(1'b0);
                cmd_index = 6'($urandom_range(63, 0));
                argument  = $urandom;
            end
            if (c == pulse_c) begin
                set_en(1'b1);
                cmd_index = ~idx;
            end
            if (c == pulse_c + 1) set_en(1'b0);
        end
        check_frame(1, d, exp, name);
        chk({name, " idle_after"}, {oe_q[48*d+2], oe_q[48*d+3], busy_q[48*d+2], busy_q[48*d+3]}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int cnt_a;
        int cnt_b;
        logic [5:0]  ri;
        logic [31:0] ra;

        vecs.push_back('{0, 6'd0,  32'h0000_0000, 48'h40_0000_0000_95, "cmd0"});
        vecs.push_back('{0, 6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, "cmd8"});
        vecs.push_back('{0, 6'd55, 32'h0000_0000, 48'h77_0000_0000_65, "cmd55"});
        vecs.push_back('{0, 6'd41, 32'h4000_0000, 48'h69_4000_0000_77, "acmd41"});
        vecs.push_back('{0, 6'd58, 32'h0000_0000, 48'h7A_0000_0000_FD, "cmd58"});
        vecs.push_back('{1, 6'd0,  32'h0000_0000, 48'h40_0000_0000_95, "div2_cmd0"});
        vecs.push_back('{1, 6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, "div2_cmd8"});

        reset = 1'b1;
        repeat (3) @(negedge ex_clk);
        chk("reset_div4", {out4, oe4, busy4, st4, fin4}, 64'b10000);
        chk("reset_div2", {out2, oe2, busy2, st2, fin2}, 64'b10000);
        @(negedge ex_clk);
        reset = 1'b0;
        repeat (2) @(negedge ex_clk);
        chk("idle_after_reset", {out4, oe4, busy4, fin4}, 64'b1000);

        foreach (vecs[i])
            send_frame(vecs[i].s, vecs[i].idx, vecs[i].arg, vecs[i].exp, -1, vecs[i].name);

        for (int i = 0; i < 6; i++) begin
            ri = 6'($urandom_range(63, 0));
            ra = $urandom;
            send_frame((i < 4) ? 0 : 1, ri, ra, model_frame(ri, ra), -1, $sformatf("rand%0d", i));
        end

        send_frame(0, 6'd17, 32'h1234_5678, model_frame(6'd17, 32'h1234_5678), 1 + 20*4, "pulse_bit20");

        // Reset asserted during bit 30
        sel = 0;
        @(negedge ex_clk);
        cmd_index = 6'd0;
        argument  = 32'h0;
        en4 = 1'b1;
        for (int c = 1; c <= 1 + 30*4; c++) begin
            @(negedge ex_clk);
            if (c == 1) en4 = 1'b0;
        end
        chk("rst_mid_pre_oe", 64'(oe4), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_line", {oe4, out4, busy4}, 64'b010);
        @(negedge ex_clk);
        reset = 1'b0;
        clr();
        repeat (48*4 + 5) begin
            @(negedge ex_clk);
            rec();
        end
        cnt_a = 0;
        cnt_b = 0;
        foreach (fin_q[i]) if (fin_q[i] !== 1'b0) cnt_a++;
        foreach (oe_q[i])  if (oe_q[i]  !== 1'b0) cnt_b++;
        chk("rst_mid_no_finished", 64'(cnt_a), 64'd0);
        chk("rst_mid_line_idle", 64'(cnt_b), 64'd0);

        send_frame(0, 6'd0, 32'h0, 48'h40_0000_0000_95, -1, "cmd0_after_reset");

        // send_en held high: two back-to-back CMD8 frames
        sel = 0;
        @(negedge ex_clk);
        cmd_index = 6'd8;
        argument  = 32'h0000_01AA;
        en4 = 1'b1;
        clr();
        rec();
        for (int c = 1; c <= 2*(48*4 + 1); c++) begin
            @(negedge ex_clk);
            rec();
        end
        en4 = 1'b0;
        check_frame(1, 4, 48'h48_0000_01AA_87, "b2b_first");
        check_frame(48*4 + 2, 4, 48'h48_0000_01AA_87, "b2b_second");
        cnt_a = 0;
        for (int c = 1; c <= 2*48*4 + 1; c++) if (oe_q[c] !== 1'b1) cnt_a++;
        chk("b2b_gap_cycles", 64'(cnt_a), 64'd1);
        repeat (3) @(negedge ex_clk);
        chk("b2b_no_third", {oe4, busy4}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
